fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/mips_pkg.sv | 37 +++
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants, fetch FSM encoding and address helpers
//                for the MIPS-style fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // First fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Sequential fetch increment and link-value offset (return past delay slot)
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  // Conditional branch target: pc + 4 + sign-extended word offset, mod 2^32
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + PC_STEP + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // j/jal target: region bits of the jump's own pc plus the 26-bit index
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [25:0] index);
    return {pc[31:28], index, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with load enable, valid bit and a
//                valid-only kill that keeps the held instruction visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        kill_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc8_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc8_q;
  logic        valid_q;

  // Capture the fetched word and its address; kill only drops the valid bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      pc8_q   <= LINK_OFFSET;
      valid_q <= 1'b0;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc8_q   <= pc_i + LINK_OFFSET;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc8_o   = pc8_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller: PC register, next-PC priority
//                mux (jr > j > taken branch > pc+4), delay-slot semantics,
//                stall hold and halt on misaligned jr target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br,
  input  logic        id_is_branch,
  input  logic        id_is_j,
  input  logic        id_is_jr,
  input  logic [31:0] id_rs,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        halt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  next_pc;
  logic         ifid_load;
  logic         ifid_kill;
  logic         take_jr;
  logic         take_j;
  logic         take_br;
  logic         jr_misaligned;

  // Decode requests only count when ID holds a real instruction
  assign take_jr       = valid_d & id_is_jr;
  assign take_j        = valid_d & id_is_j;
  assign take_br       = valid_d & id_is_branch & br;
  assign jr_misaligned = take_jr & (id_rs[1:0] != 2'b00);

  // Next sequential/redirect address, highest priority first
  always_comb begin
    next_pc = pc_f_q + PC_STEP;
    if (take_jr) begin
      next_pc = id_rs;
    end else if (take_j) begin
      next_pc = jump_target(pc_d, instr_d[25:0]);
    end else if (take_br) begin
      next_pc = branch_target(pc_d, instr_d[15:0]);
    end
  end

  // FSM next state plus PC and IF/ID control
  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    ifid_load = 1'b0;
    ifid_kill = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Single boot cycle: first fetch at RESET_PC goes into IF/ID
        ifid_load = 1'b1;
        pc_f_d    = pc_f_q + PC_STEP;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (jr_misaligned) begin
            // Freeze fetch; instruction stays visible but is no longer valid
            ifid_kill = 1'b1;
            state_d   = ST_HALT;
          end else begin
            ifid_load = 1'b1;
            pc_f_d    = next_pc;
          end
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and fetch-address registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_f_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .kill_i  (ifid_kill),
    .instr_i (imem_rdata),
    .pc_i    (pc_f_q),
    .instr_o (instr_d),
    .pc_o    (pc_d),
    .pc8_o   (pc8_d),
    .valid_o (valid_d)
  );

  assign pc_f = pc_f_q;
  assign halt = (state_q == ST_HALT);

endmodule
`default_nettype wire
